// File: rtl/alu_ctrl_stage_if.sv
// Bundle of the decode-stage inputs (IF/ID instruction, register reads, pipeline
// control) and the registered ALU controls and operands for the execute stage.
interface alu_ctrl_stage_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
);
  logic [31:0]       Instr;
  logic              InstrValid;
  logic              Stall;
  logic              Flush;
  logic [DATA_W-1:0] RsData;
  logic [DATA_W-1:0] RtData;
  logic [5:0]        AluCon;
  logic [DATA_W-1:0] OpA;
  logic [DATA_W-1:0] OpB;
  logic              ValidOut;
  logic              Illegal;
  logic [CNT_W-1:0]  IllegalCount;

  modport master (
    output Instr, InstrValid, Stall, Flush, RsData, RtData,
    input  AluCon, OpA, OpB, ValidOut, Illegal, IllegalCount
  );

  modport slave (
    input  Instr, InstrValid, Stall, Flush, RsData, RtData,
    output AluCon, OpA, OpB, ValidOut, Illegal, IllegalCount
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// ID/EX register: decodes the MIPS opcode/funct into the ALU function code,
// selects and extends the operands, and registers them with stall/flush control.
module alu_ctrl_stage #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic            clk,
  input  logic            reset,
  alu_ctrl_stage_if.slave bus
);

  typedef enum logic [5:0] {
    F_SLL  = 6'b000000, F_SRL  = 6'b000010, F_SRA  = 6'b000011,
    F_SLLV = 6'b000100, F_SRLV = 6'b000110, F_SRAV = 6'b000111,
    F_ADD  = 6'b100000, F_ADDU = 6'b100001, F_SUB  = 6'b100010,
    F_SUBU = 6'b100011, F_AND  = 6'b100100, F_OR   = 6'b100101,
    F_XOR  = 6'b100110, F_NOR  = 6'b100111, F_SLT  = 6'b101010,
    F_SLTU = 6'b101011
  } alu_fn_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000, OP_BEQ  = 6'b000100, OP_BNE   = 6'b000101,
    OP_ADDI  = 6'b001000, OP_ADDIU = 6'b001001, OP_SLTI = 6'b001010,
    OP_SLTIU = 6'b001011, OP_ANDI = 6'b001100, OP_ORI   = 6'b001101,
    OP_XORI  = 6'b001110, OP_LUI  = 6'b001111, OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  logic [5:0]        opcode, funct;
  logic [4:0]        shamt;
  logic [15:0]       imm;
  logic [DATA_W-1:0] sext, zext, shamt_ext;

  logic [5:0]        dec_con;
  logic [DATA_W-1:0] dec_a, dec_b;
  logic              dec_ill;

  logic [5:0]        alu_con_q;
  logic [DATA_W-1:0] op_a_q, op_b_q;
  logic              valid_q, illegal_q;
  logic [CNT_W-1:0]  ill_cnt_q;

  assign opcode    = bus.Instr[31:26];
  assign funct     = bus.Instr[5:0];
  assign shamt     = bus.Instr[10:6];
  assign imm       = bus.Instr[15:0];
  assign sext      = {{(DATA_W-16){imm[15]}}, imm};
  assign zext      = {{(DATA_W-16){1'b0}}, imm};
  assign shamt_ext = {{(DATA_W-5){1'b0}}, shamt};

  always_comb begin
    dec_con = F_ADD;
    dec_a   = '0;
    dec_b   = '0;
    dec_ill = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
            dec_con = funct;
            dec_a   = bus.RsData;
            dec_b   = bus.RtData;
          end
          F_SLL, F_SRL, F_SRA: begin
            dec_con = funct;
            dec_a   = bus.RtData;
            dec_b   = shamt_ext;
          end
          // variable shifts: the ALU takes the amount from OpB[4:0]
          F_SLLV, F_SRLV, F_SRAV: begin
            dec_con = funct;
            dec_a   = bus.RtData;
            dec_b   = bus.RsData;
          end
          default: dec_ill = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: begin
        dec_con = F_ADD;
        dec_a   = bus.RsData;
        dec_b   = sext;
      end
      OP_ADDIU: begin dec_con = F_ADDU; dec_a = bus.RsData; dec_b = sext; end
      OP_SLTI:  begin dec_con = F_SLT;  dec_a = bus.RsData; dec_b = sext; end
      OP_SLTIU: begin dec_con = F_SLTU; dec_a = bus.RsData; dec_b = sext; end
      OP_ANDI:  begin dec_con = F_AND;  dec_a = bus.RsData; dec_b = zext; end
      OP_ORI:   begin dec_con = F_OR;   dec_a = bus.RsData; dec_b = zext; end
      OP_XORI:  begin dec_con = F_XOR;  dec_a = bus.RsData; dec_b = zext; end
      OP_LUI: begin
        dec_con = F_SLL;
        dec_a   = zext;
        dec_b   = DATA_W'(16);
      end
      OP_BEQ, OP_BNE: begin
        dec_con = F_SUBU;
        dec_a   = bus.RsData;
        dec_b   = bus.RtData;
      end
      default: dec_ill = 1'b1;
    endcase
  end

  // priority: reset > Flush > Stall > load; Flush never counts the discarded instruction
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_con_q <= F_ADD;
      op_a_q    <= '0;
      op_b_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      ill_cnt_q <= '0;
    end else if (bus.Flush) begin
      alu_con_q <= F_ADD;
      op_a_q    <= '0;
      op_b_q    <= '0;
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else if (!bus.Stall) begin
      if (!bus.InstrValid) begin
        alu_con_q <= F_ADD;
        op_a_q    <= '0;
        op_b_q    <= '0;
        valid_q   <= 1'b0;
        illegal_q <= 1'b0;
      end else if (dec_ill) begin
        alu_con_q <= F_ADD;
        op_a_q    <= '0;
        op_b_q    <= '0;
        valid_q   <= 1'b1;
        illegal_q <= 1'b1;
        if (ill_cnt_q != '1) ill_cnt_q <= ill_cnt_q + CNT_W'(1);
      end else begin
        alu_con_q <= dec_con;
        op_a_q    <= dec_a;
        op_b_q    <= dec_b;
        valid_q   <= 1'b1;
        illegal_q <= 1'b0;
      end
    end
  end

  assign bus.AluCon       = alu_con_q;
  assign bus.OpA          = op_a_q;
  assign bus.OpB          = op_b_q;
  assign bus.ValidOut     = valid_q;
  assign bus.Illegal      = illegal_q;
  assign bus.IllegalCount = ill_cnt_q;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Scoreboard bench for alu_ctrl_stage: each driven edge pushes its hand-computed
// expected register contents; a monitor pops and compares after every edge.
module tb_alu_ctrl_stage;
  logic clk = 1'b0;
  logic reset;

  alu_ctrl_stage_if #(.DATA_W(32), .CNT_W(8)) bus ();

  alu_ctrl_stage #(.DATA_W(32), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  con;
    logic [31:0] a;
    logic [31:0] b;
    logic        v;
    logic        ill;
    logic [7:0]  cnt;
  } exp_t;

  exp_t  q[$];
  string nq[$];
  exp_t  last_e;
  logic [7:0] ecnt;
  int total = 0;
  int bad   = 0;

  localparam logic [5:0] ADDC = 6'b100000;

  // monitor
  exp_t  me;
  string mn;
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      me = q.pop_front();
      mn = nq.pop_front();
      total++;
      if (bus.AluCon !== me.con || bus.OpA !== me.a || bus.OpB !== me.b ||
          bus.ValidOut !== me.v || bus.Illegal !== me.ill || bus.IllegalCount !== me.cnt) begin
        bad++;
        $display("FAIL %s: got con=%b a=%h b=%h v=%b ill=%b cnt=%0d, want con=%b a=%h b=%h v=%b ill=%b cnt=%0d",
                 mn, bus.AluCon, bus.OpA, bus.OpB, bus.ValidOut, bus.Illegal, bus.IllegalCount,
                 me.con, me.a, me.b, me.v, me.ill, me.cnt);
      end
    end
  end

  task automatic drive(input logic r, input logic st, input logic fl, input logic iv,
                       input logic [31:0] ins, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    reset          = r;
    bus.Stall      = st;
    bus.Flush      = fl;
    bus.InstrValid = iv;
    bus.Instr      = ins;
    bus.RsData     = rs;
    bus.RtData     = rt;
  endtask

  task automatic push(input string nm, input exp_t e);
    q.push_back(e);
    nq.push_back(nm);
    last_e = e;
  endtask

  task automatic t_load(input string nm, input logic [31:0] ins, input logic [31:0] rs,
                        input logic [31:0] rt, input logic [5:0] con,
                        input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    drive(1'b0, 1'b0, 1'b0, 1'b1, ins, rs, rt);
    e = '{con: con, a: a, b: b, v: 1'b1, ill: 1'b0, cnt: ecnt};
    push(nm, e);
  endtask

  task automatic t_ill(input string nm, input logic [31:0] ins, input logic iv);
    exp_t e;
    drive(1'b0, 1'b0, 1'b0, iv, ins, 32'h1111_1111, 32'h2222_2222);
    if (iv && ecnt != 8'hFF) ecnt = ecnt + 8'd1;
    e = '{con: ADDC, a: '0, b: '0, v: iv, ill: iv, cnt: ecnt};
    push(nm, e);
  endtask

  task automatic t_stall(input string nm, input logic [31:0] ins);
    drive(1'b0, 1'b1, 1'b0, 1'b1, ins, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    push(nm, last_e);
  endtask

  task automatic t_flush(input string nm, input logic st, input logic [31:0] ins);
    exp_t e;
    drive(1'b0, st, 1'b1, 1'b1, ins, 32'h5, 32'h7);
    e = '{con: ADDC, a: '0, b: '0, v: 1'b0, ill: 1'b0, cnt: ecnt};
    push(nm, e);
  endtask

  task automatic t_reset(input string nm, input logic st, input logic [31:0] ins);
    exp_t e;
    drive(1'b1, st, 1'b0, 1'b1, ins, 32'h5, 32'h7);
    ecnt = '0;
    e = '{con: ADDC, a: '0, b: '0, v: 1'b0, ill: 1'b0, cnt: ecnt};
    push(nm, e);
  endtask

  initial begin
    reset = 1'b1;
    bus.Stall = 1'b0; bus.Flush = 1'b0; bus.InstrValid = 1'b0;
    bus.Instr = '0; bus.RsData = '0; bus.RtData = '0;
    ecnt = '0;

    t_reset("reset0", 1'b0, 32'h0022_1820);
    t_reset("reset1", 1'b0, 32'h0022_1820);

    t_load("add",   32'h0022_1820, 32'd5, 32'd7, 6'b100000, 32'd5, 32'd7);
    t_load("sll",   32'h0001_1100, 32'd9, 32'h3, 6'b000000, 32'h3, 32'd4);
    t_load("srav",  32'h0022_1807, 32'h25, 32'h8000_0000, 6'b000111, 32'h8000_0000, 32'h25);
    t_load("addi",  32'h2022_FFFC, 32'd10, 32'd1, 6'b100000, 32'd10, 32'hFFFF_FFFC);
    t_load("ori",   32'h3422_8001, 32'h00F0_0000, 32'd1, 6'b100101, 32'h00F0_0000, 32'h0000_8001);
    t_load("lui",   32'h3C02_1234, 32'h77, 32'h88, 6'b000000, 32'h0000_1234, 32'd16);
    t_load("sltiu", 32'h2C22_FFFF, 32'd3, 32'd4, 6'b101011, 32'd3, 32'hFFFF_FFFF);
    t_load("beq",   32'h1022_0003, 32'd11, 32'd12, 6'b100011, 32'd11, 32'd12);
    t_load("lw",    32'h8C22_0004, 32'h1000, 32'd0, 6'b100000, 32'h1000, 32'd4);
    t_load("nor",   32'h0022_1827, 32'hF0F0, 32'h0F0F, 6'b100111, 32'hF0F0, 32'h0F0F);
    t_ill("ill_funct", 32'h0022_1801, 1'b1);
    t_ill("bubble_legal", 32'h0022_1820, 1'b0);

    t_load("add_pre_stall", 32'h0022_1820, 32'd5, 32'd7, 6'b100000, 32'd5, 32'd7);
    t_stall("stall1", 32'h3C02_1234);
    t_stall("stall2", 32'hFC00_0000);
    t_stall("stall3", 32'h0001_1100);
    t_flush("stall_flush", 1'b1, 32'hFC00_0000);
    t_load("sub_after_flush", 32'h0022_1822, 32'd9, 32'd4, 6'b100010, 32'd9, 32'd4);

    for (int i = 0; i < 260; i++) t_ill("ill_sat", 32'hFC00_0000, 1'b1);
    t_ill("ill_invalid", 32'hFC00_0000, 1'b0);
    t_flush("flush_hold_cnt", 1'b0, 32'hFC00_0000);

    t_ill("ill_pre_reset", 32'hFC00_0000, 1'b1);
    t_stall("ill_stalled", 32'hFC00_0000);
    t_reset("reset_in_stall", 1'b1, 32'hFC00_0000);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'h0022_1820, 32'd5, 32'd7);
    push("release_stalled", last_e);
    t_load("first_load", 32'h0022_1820, 32'd21, 32'd22, 6'b100000, 32'd21, 32'd22);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
